motor_speed_ctrl: RTL

Sequencing controller for the four-level PWM datapath in the motor path. Generates the 10-bit free-running period counter that feeds the PWM comparator, runs a speed state machine driven by speed/stop buttons, and selects one of the four returned PWM levels as the motor drive. An optional auto-off timer stops the motor after a button-programmed number of seconds.

---
 rtl/motor_speed_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/motor_speed_ctrl.sv
// Speed sequencer for the four-level PWM motor path: period counter, speed FSM, level select.
// Optional auto-off timer is built when MOTOR_TIMER_EN is defined.
module motor_speed_ctrl #(
   parameter int CNT_MAX    = 999,
   parameter int TICK_DIV   = 100_000_000,
   parameter int TIMER_STEP = 3,
   parameter int TIMER_MAX  = 9
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_speed,
   input  logic       i_btn_stop,
   input  logic       i_btn_timer,
   input  logic [3:0] i_pwm,
   output logic [9:0] o_counter,
   output logic       o_motor,
   output logic [2:0] o_speed,
   output logic [3:0] o_timer
);

   typedef enum logic [2:0] {
      ST_STOP = 3'd0,
      ST_SPD1 = 3'd1,
      ST_SPD2 = 3'd2,
      ST_SPD3 = 3'd3,
      ST_SPD4 = 3'd4
   } state_e;

   localparam logic [9:0] CNT_LAST = 10'(CNT_MAX);

   state_e     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic       spd_dly_q, spd_dly_d;
   logic       stop_dly_q, stop_dly_d;
   logic       spd_press;
   logic       stop_press;
   logic       expire;
   logic       motor;

   assign spd_press  = i_btn_speed & ~spd_dly_q;
   assign stop_press = i_btn_stop & ~stop_dly_q;

   always_comb begin
      cnt_d      = (cnt_q == CNT_LAST) ? 10'd0 : cnt_q + 10'd1;
      spd_dly_d  = i_btn_speed;
      stop_dly_d = i_btn_stop;
   end

`ifdef MOTOR_TIMER_EN
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0]    TMR_MAX  = 4'(TIMER_MAX);
   localparam logic [4:0]    TMR_STEP = 5'(TIMER_STEP);

   logic          tmr_dly_q, tmr_dly_d;
   logic [3:0]    tmr_q, tmr_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          tmr_press;
   logic          tmr_load;
   logic          run;
   logic          tick;
   logic [4:0]    tmr_sum;

   assign tmr_press = i_btn_timer & ~tmr_dly_q;
   assign tmr_load  = tmr_press && (state_q != ST_STOP) && !stop_press;
   assign run       = (state_q != ST_STOP) && (tmr_q != 4'd0);
   assign tick      = run && (pre_q == PRE_LAST);
   assign tmr_sum   = {1'b0, tmr_q} + TMR_STEP;

   // A load restarts the prescaler so expiry lands exactly tmr*TICK_DIV clocks later.
   always_comb begin
      tmr_dly_d = i_btn_timer;
      tmr_d     = tmr_q;
      expire    = 1'b0;
      if (!run || tick || tmr_load || stop_press)
         pre_d = '0;
      else
         pre_d = pre_q + PW'(1);
      if (stop_press) begin
         tmr_d = 4'd0;
      end else if (tmr_load) begin
         if (tmr_q == TMR_MAX)
            tmr_d = 4'd0;
         else if (tmr_sum > {1'b0, TMR_MAX})
            tmr_d = TMR_MAX;
         else
            tmr_d = tmr_sum[3:0];
      end else if (tick) begin
         expire = (tmr_q == 4'd1);
         tmr_d  = tmr_q - 4'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tmr_dly_q <= 1'b0;
         tmr_q     <= 4'd0;
         pre_q     <= '0;
      end else begin
         tmr_dly_q <= tmr_dly_d;
         tmr_q     <= tmr_d;
         pre_q     <= pre_d;
      end
   end

   assign o_timer = tmr_q;
`else
   localparam int unused_cfg = TICK_DIV + TIMER_STEP + TIMER_MAX;

   logic unused_btn_timer;

   assign unused_btn_timer = i_btn_timer;
   assign expire           = 1'b0;
   assign o_timer          = 4'd0;
`endif

   // Stop beats expiry beats speed; overlapping requests are expected here.
   always_comb begin
      state_d = state_q;
      priority case (1'b1)
         stop_press: state_d = ST_STOP;
         expire:     state_d = ST_STOP;
         spd_press: begin
            unique case (state_q)
               ST_STOP: state_d = ST_SPD1;
               ST_SPD1: state_d = ST_SPD2;
               ST_SPD2: state_d = ST_SPD3;
               ST_SPD3: state_d = ST_SPD4;
               ST_SPD4: state_d = ST_SPD1;
               default: state_d = ST_STOP;
            endcase
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_STOP;
         cnt_q      <= 10'd0;
         spd_dly_q  <= 1'b0;
         stop_dly_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         spd_dly_q  <= spd_dly_d;
         stop_dly_q <= stop_dly_d;
      end
   end

   always_comb begin
      motor = 1'b0;
      unique case (state_q)
         ST_STOP: motor = 1'b0;
         ST_SPD1: motor = i_pwm[0];
         ST_SPD2: motor = i_pwm[1];
         ST_SPD3: motor = i_pwm[2];
         ST_SPD4: motor = i_pwm[3];
         default: motor = 1'b0;
      endcase
   end

   assign o_motor   = motor;
   assign o_speed   = state_q;
   assign o_counter = cnt_q;

endmodule
